// File: rtl/mac_pkg.sv
// mac_pkg: shared widths, FSM state type and saturation limits for the MAC datapath.
package mac_pkg;

    localparam int PROD_W = 64;
    localparam int ACC_W  = 72;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam logic [PROD_W-1:0] SAT_POS = {1'b0, {(PROD_W-1){1'b1}}};
    localparam logic [PROD_W-1:0] SAT_NEG = {1'b1, {(PROD_W-1){1'b0}}};

    function automatic logic [ACC_W-1:0] sext(input logic [PROD_W-1:0] p);
        return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
    endfunction

endpackage

// File: rtl/product_accumulator_if.sv
// product_accumulator_if: burst control, product input and result output handshakes.
interface product_accumulator_if;
    import mac_pkg::*;

    logic              start;
    logic [CNT_W-1:0]  len;
    logic              busy;
    logic              prod_valid;
    logic              prod_ready;
    logic [PROD_W-1:0] prod;
    logic              res_valid;
    logic              res_ready;
    logic [PROD_W-1:0] res;
    logic              ovf;

    modport master (
        output start, len, prod_valid, prod, res_ready,
        input  busy, prod_ready, res_valid, res, ovf
    );

    modport slave (
        input  start, len, prod_valid, prod, res_ready,
        output busy, prod_ready, res_valid, res, ovf
    );

endinterface

// File: rtl/product_acc_clamp.sv
// product_acc_clamp: reduces the wide accumulator to a PROD_W result plus overflow flag.
// Defining ACC_SAT_EN clamps an overflowing result to the signed PROD_W limits instead of truncating.
module product_acc_clamp
    import mac_pkg::*;
(
    input  logic [ACC_W-1:0]  acc,
    output logic [PROD_W-1:0] res,
    output logic              ovf
);

    // Fits in PROD_W signed only when every bit from the result sign upward agrees.
    assign ovf = !((&acc[ACC_W-1:PROD_W-1]) || !(|acc[ACC_W-1:PROD_W-1]));

`ifdef ACC_SAT_EN
    assign res = ovf ? (acc[ACC_W-1] ? SAT_NEG : SAT_POS) : acc[PROD_W-1:0];
`else
    assign res = acc[PROD_W-1:0];
`endif

endmodule

// File: rtl/product_accumulator.sv
// product_accumulator: sums a burst of signed products and returns one result per burst.
// Result saturation is selected by the ACC_SAT_EN macro inside product_acc_clamp.
module product_accumulator
    import mac_pkg::*;
(
    input  logic clk,
    input  logic rst,
    product_accumulator_if.slave bus
);

    state_t            state, state_nx;
    logic [ACC_W-1:0]  acc, acc_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [PROD_W-1:0] res_q, res_c;
    logic              ovf_q, ovf_c;
    logic              prod_ready, res_valid, take;

    assign take = (state == ACCUM) && prod_ready && bus.prod_valid;

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        cnt_nx   = cnt;
        case (state)
            IDLE: if (bus.start) begin
                acc_nx   = '0;
                cnt_nx   = bus.len;
                state_nx = (bus.len == '0) ? DONE : ACCUM;
            end
            ACCUM: if (take) begin
                acc_nx   = acc + sext(bus.prod);
                cnt_nx   = cnt - CNT_W'(1);
                state_nx = (cnt == CNT_W'(1)) ? DONE : ACCUM;
            end
            DONE: state_nx = (res_valid && bus.res_ready) ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    // Clamp sees the next accumulator so the result registers on the final accept edge.
    product_acc_clamp u_clamp (
        .acc (acc_nx),
        .res (res_c),
        .ovf (ovf_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            prod_ready <= 1'b0;
            res_valid  <= 1'b0;
            res_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state      <= state_nx;
            acc        <= acc_nx;
            cnt        <= cnt_nx;
            prod_ready <= state_nx == ACCUM;
            res_valid  <= state_nx == DONE;
            if (state_nx == DONE && state != DONE) begin
                res_q <= res_c;
                ovf_q <= ovf_c;
            end
        end
    end

    assign bus.busy       = state != IDLE;
    assign bus.prod_ready = prod_ready;
    assign bus.res_valid  = res_valid;
    assign bus.res        = res_q;
    assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: randomized and directed bursts checked against a burst-level sum model.
module tb_product_accumulator;

    localparam logic signed [71:0] PMAX = 72'sh7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [71:0] PMIN = -PMAX - 72'sd1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    product_accumulator_if bus();

    product_accumulator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a burst is just a count of products and their exact sum.
    int                m_phase = 0;
    int                m_need = 0;
    int                m_got = 0;
    logic signed [71:0] m_sum = 0;
    logic [63:0]       m_res = 0;
    logic              m_ovf = 0;

    task automatic finish_burst();
        m_phase = 2;
        m_ovf = (m_sum > PMAX) || (m_sum < PMIN);
`ifdef ACC_SAT_EN
        m_res = m_ovf ? (m_sum < 0 ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF) : m_sum[63:0];
`else
        m_res = m_sum[63:0];
`endif
    endtask

    always @(negedge clk) begin
        if (rst) begin
            m_phase = 0;
            m_sum = 0;
            m_res = 0;
            m_ovf = 0;
        end else begin
            chk("busy", 72'(bus.busy), 72'(m_phase != 0));
            chk("prod_ready", 72'(bus.prod_ready), 72'(m_phase == 1));
            chk("res_valid", 72'(bus.res_valid), 72'(m_phase == 2));
            chk("res", 72'(bus.res), 72'(m_res));
            chk("ovf", 72'(bus.ovf), 72'(m_ovf));
            if (m_phase == 0 && bus.start) begin
                m_sum = 0;
                m_got = 0;
                m_need = int'(bus.len);
                if (m_need == 0) finish_burst();
                else m_phase = 1;
            end else if (m_phase == 1 && bus.prod_valid) begin
                m_sum = m_sum + {{8{bus.prod[63]}}, bus.prod};
                m_got++;
                if (m_got == m_need) finish_burst();
            end else if (m_phase == 2 && bus.res_ready) begin
                m_phase = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input int n);
        bus.start = 1'b1;
        bus.len = 16'(n);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send(input logic [63:0] v);
        logic rdy;
        bus.prod_valid = 1'b1;
        bus.prod = v;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            rdy = bus.prod_ready;
            tick();
            if (rdy) return;
        end
        chk("send_timeout", 72'd1, 72'd0);
    endtask

    task automatic get_result(input string name, input bit lit, input logic [63:0] er,
                              input logic eo, input int hold);
        bit seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = bus.res_valid;
        end
        if (!seen) chk({name, "_timeout"}, 72'd1, 72'd0);
        if (lit) begin
            chk({name, "_res"}, 72'(bus.res), 72'(er));
            chk({name, "_ovf"}, 72'(bus.ovf), 72'(eo));
        end
        tick();
        repeat (hold) tick();
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    initial begin
        bus.start = 0;
        bus.len = 0;
        bus.prod_valid = 0;
        bus.prod = 0;
        bus.res_ready = 0;
        #2;
        chk("rst_busy", 72'(bus.busy), 72'd0);
        chk("rst_ready", 72'(bus.prod_ready), 72'd0);
        chk("rst_valid", 72'(bus.res_valid), 72'd0);
        chk("rst_res", 72'(bus.res), 72'd0);
        repeat (3) tick();
        rst = 1'b0;
        tick();

        start_burst(3);
        send(64'd5);
        send(-64'sd2);
        send(64'd7);
        bus.prod_valid = 0;
        get_result("t1", 1, 64'd10, 1'b0, 0);

        start_burst(0);
        get_result("t2", 1, 64'd0, 1'b0, 1);

        start_burst(2);
        send(64'h7FFF_FFFF_FFFF_FFFF);
        send(64'h7FFF_FFFF_FFFF_FFFF);
        bus.prod_valid = 0;
`ifdef ACC_SAT_EN
        get_result("t3", 1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 0);
`else
        get_result("t3", 1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 0);
`endif

        start_burst(4);
        for (int k = 1; k <= 4; k++) begin
            send(64'(k * 100));
            bus.prod_valid = 0;
            bus.start = 1'b1;
            bus.len = 16'd9;
            tick();
            bus.start = 1'b0;
        end
        bus.start = 1'b1;
        get_result("t4", 1, 64'd1000, 1'b0, 5);
        bus.start = 1'b0;
        tick();

        start_burst(4);
        send(64'd11);
        send(64'd22);
        bus.prod_valid = 0;
        rst = 1'b1;
        #1;
        chk("t5_busy", 72'(bus.busy), 72'd0);
        chk("t5_ready", 72'(bus.prod_ready), 72'd0);
        chk("t5_valid", 72'(bus.res_valid), 72'd0);
        chk("t5_res", 72'(bus.res), 72'd0);
        chk("t5_ovf", 72'(bus.ovf), 72'd0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        start_burst(1);
        send(-64'sd9);
        bus.prod_valid = 0;
        get_result("t5b", 1, 64'hFFFF_FFFF_FFFF_FFF7, 1'b0, 0);

        start_burst(2);
        send(64'd3);
        send(64'd4);
        bus.prod_valid = 0;
        get_result("t6a", 1, 64'd7, 1'b0, 0);
        start_burst(1);
        send(-64'sd1);
        bus.prod_valid = 0;
        get_result("t6b", 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0);

        for (int b = 0; b < 40; b++) begin
            int n = int'($urandom_range(0, 6));
            start_burst(n);
            for (int k = 0; k < n; k++) begin
                logic [63:0] v;
                v = {$urandom, $urandom};
                if ($urandom_range(0, 2) == 0) v = {{40{v[63]}}, v[23:0]};
                send(v);
                if ($urandom_range(0, 1) == 1) begin
                    bus.prod_valid = 0;
                    bus.start = 1'($urandom);
                    repeat ($urandom_range(1, 2)) tick();
                    bus.start = 0;
                end
            end
            bus.prod_valid = 0;
            get_result("rnd", 0, 64'd0, 1'b0, int'($urandom_range(0, 3)));
        end

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
